// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 receive path.
`timescale 1ns/1ps
package ps2_rx_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int   PS2_DATA_W     = 8;
    localparam int   PS2_FRAME_BITS = 11;
    localparam int   PS2_TMO_W      = 13;

    // An idle PS/2 bus floats high, so synchronizers come out of reset at 1
    localparam logic PS2_SYNC_RST   = 1'b1;

    // Odd parity over data plus parity bit means the total count of ones is odd
    function automatic logic ps2_parity_ok(input logic [PS2_DATA_W-1:0] data,
                                           input logic                  par);
        return (^{data, par}) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_rx_controller_if.sv
// Byte delivery port: valid/ready handshake plus one-cycle status pulses.
`timescale 1ns/1ps
interface ps2_rx_controller_if;
    import ps2_rx_pkg::*;

    logic [PS2_DATA_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun;

    // Receiver side drives the byte and status
    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    // Consumer side accepts bytes
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/ps2_edge_detect.sv
// Brings the raw PS/2 clock/data pins into the clk domain and flags
// falling edges of the PS/2 clock together with the data bit sampled
// at the same synchronizer depth.
`timescale 1ns/1ps
module ps2_edge_detect
    import ps2_rx_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic rx_bit
);

    logic [1:0] clk_sync_q;
    logic [1:0] clk_sync_d;
    logic [1:0] data_sync_q;
    logic [1:0] data_sync_d;
    logic       hist_q;
    logic       hist_d;

    // Shift both pins through two stages; history trails the synced clock
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        hist_d      = clk_sync_q[1];
    end

    // Synchronizer and history registers, idle-high after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= {2{PS2_SYNC_RST}};
            data_sync_q <= {2{PS2_SYNC_RST}};
            hist_q      <= PS2_SYNC_RST;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            hist_q      <= hist_d;
        end
    end

    assign fall   = hist_q & ~clk_sync_q[1];
    assign rx_bit = data_sync_q[1];

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 receive controller: frames start/8 data/odd parity/stop bits off
// synchronized ps2_clk falling edges and hands each good byte to a
// single-entry valid/ready output slot.
`timescale 1ns/1ps
module ps2_rx_controller
    import ps2_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 6000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    input  logic                enable,
    ps2_rx_controller_if.master rx
);

    // The timeout counter is a fixed 13 bits wide
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= 8192) begin : g_tmo_range_check
        $error("ps2_rx_controller: TIMEOUT_CYCLES must be in 2..8191");
    end

    localparam logic [PS2_TMO_W-1:0] TMO_LAST = PS2_TMO_W'(TIMEOUT_CYCLES - 1);

    logic fall;
    logic rx_bit;

    ps2_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .rx_bit   (rx_bit)
    );

    ps2_state_e            state_q,      state_d;
    logic [2:0]            bit_cnt_q,    bit_cnt_d;
    logic [PS2_DATA_W-1:0] shreg_q,      shreg_d;
    logic                  parity_q,     parity_d;
    logic [PS2_TMO_W-1:0]  tmo_q,        tmo_d;
    logic [PS2_DATA_W-1:0] rx_data_q,    rx_data_d;
    logic                  rx_valid_q,   rx_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q,  frame_err_d;
    logic                  overrun_q,    overrun_d;

    // Next-state, datapath and output-slot logic
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        parity_d     = parity_q;
        tmo_d        = tmo_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        // Consumer takes the byte; a same-edge delivery below re-arms valid
        if (rx_valid_q && rx.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        // Inter-edge watchdog only runs while a frame is in flight
        if (state_q == ST_IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (!enable) begin
            // Silent abort; the output slot is left alone
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tmo_d     = '0;
        end else if (state_q != ST_IDLE && !fall && tmo_q == TMO_LAST) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            tmo_d       = '0;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {rx_bit, shreg_q[PS2_DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = rx_bit;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!rx_bit) begin
                        frame_err_d = 1'b1;
                    end else if (!ps2_parity_ok(shreg_q, parity_q)) begin
                        parity_err_d = 1'b1;
                    end else if (!rx_valid_q || rx.rx_ready) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx.rx_data    = rx_data_q;
    assign rx.rx_valid   = rx_valid_q;
    assign rx.parity_err = parity_err_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Directed bench for ps2_rx_controller: bit-banged PS/2 frames with
// hand-computed bytes and status expectations.
`timescale 1ns/1ps
module tb_ps2_rx_controller;

    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic enable   = 1'b1;

    ps2_rx_controller_if rx_if ();

    ps2_rx_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .enable   (enable),
        .rx       (rx_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pe_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int val_cnt = 0;

    // Count high cycles of each status output
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_if.parity_err) pe_cnt++;
            if (rx_if.frame_err)  fe_cnt++;
            if (rx_if.overrun)    ov_cnt++;
            if (rx_if.rx_valid)   val_cnt++;
        end
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(stop);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_if.rx_data); end
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_if.rx_valid); end
        checks++; if (rx_if.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b exp 0", rx_if.parity_err); end
        checks++; if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", rx_if.frame_err); end
        checks++; if (rx_if.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", rx_if.overrun); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        int pe0, fe0, ov0, v0;
        logic [7:0] d;
        d = 8'h5A;
        pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt; v0 = val_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(1'b1);
        // stop bit driven by hand to time the delivery edge
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk);          // edge k: low first sampled
        @(posedge clk); #1;      // edge k+1
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL good_early_valid got %b exp 0", rx_if.rx_valid); end
        @(posedge clk); #1;      // edge k+2
        checks++; if (rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL good_valid_k2 got %b exp 1", rx_if.rx_valid); end
        checks++; if (rx_if.rx_data !== 8'h5A) begin errors++; $display("FAIL good_rx_data got %h exp 5a", rx_if.rx_data); end
        @(posedge clk); #1;
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL good_valid_drop got %b exp 0", rx_if.rx_valid); end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (val_cnt - v0 !== 1) begin errors++; $display("FAIL good_valid_cycles got %0d exp 1", val_cnt - v0); end
        checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin errors++; $display("FAIL good_no_errors got %0d exp 0", (pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0)); end
        $display("test_good_frame byte 5a done");
    endtask

    task automatic test_parity_err();
        int pe0, fe0, v0;
        pe0 = pe_cnt; fe0 = fe_cnt; v0 = val_cnt;
        send_frame(8'h5A, 1'b0, 1'b1);
        checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL parity_pulse got %0d exp 1", pe_cnt - pe0); end
        checks++; if (val_cnt - v0 !== 0) begin errors++; $display("FAIL parity_no_valid got %0d exp 0", val_cnt - v0); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL parity_no_frame_err got %0d exp 0", fe_cnt - fe0); end
        send_frame(8'h12, 1'b1, 1'b1);
        checks++; if (rx_if.rx_data !== 8'h12) begin errors++; $display("FAIL parity_next_data got %h exp 12", rx_if.rx_data); end
        checks++; if (val_cnt - v0 !== 1) begin errors++; $display("FAIL parity_next_valid got %0d exp 1", val_cnt - v0); end
        checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL parity_next_clean got %0d exp 1", pe_cnt - pe0); end
        $display("test_parity_err bad 5a then 12 done");
    endtask

    task automatic test_stop_err();
        int pe0, fe0, v0;
        pe0 = pe_cnt; fe0 = fe_cnt; v0 = val_cnt;
        send_frame(8'hFF, 1'b1, 1'b0);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL stop_frame_err got %0d exp 1", fe_cnt - fe0); end
        checks++; if (pe_cnt - pe0 !== 0) begin errors++; $display("FAIL stop_no_parity got %0d exp 0", pe_cnt - pe0); end
        checks++; if (val_cnt - v0 !== 0) begin errors++; $display("FAIL stop_no_valid got %0d exp 0", val_cnt - v0); end
        checks++; if (rx_if.rx_data !== 8'h12) begin errors++; $display("FAIL stop_data_kept got %h exp 12", rx_if.rx_data); end
        $display("test_stop_err ff done");
    endtask

    task automatic test_timeout();
        int fe0, v0, n;
        logic [3:0] part;
        part = 4'b1101;
        fe0 = fe_cnt; v0 = val_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(part[i]);
        n = 0;
        while (rx_if.frame_err !== 1'b1 && n < 2 * TMO) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rx_if.frame_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %b exp 1 after %0d cycles", rx_if.frame_err, n); end
        checks++; if (n < TMO / 2 || n > TMO) begin errors++; $display("FAIL timeout_latency got %0d exp %0d..%0d", n, TMO / 2, TMO); end
        repeat (5) @(negedge clk);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL timeout_pulse_width got %0d exp 1", fe_cnt - fe0); end
        send_frame(8'h33, 1'b1, 1'b1);
        checks++; if (rx_if.rx_data !== 8'h33) begin errors++; $display("FAIL timeout_next_data got %h exp 33", rx_if.rx_data); end
        checks++; if (val_cnt - v0 !== 1) begin errors++; $display("FAIL timeout_next_valid got %0d exp 1", val_cnt - v0); end
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL timeout_next_clean got %0d exp 1", fe_cnt - fe0); end
        $display("test_timeout then 33 done");
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        checks++; if (rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %b exp 1", rx_if.rx_valid); end
        checks++; if (rx_if.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_first_data got %h exp 11", rx_if.rx_data); end
        checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL ovr_first_no_pulse got %0d exp 0", ov_cnt - ov0); end
        send_frame(8'h22, 1'b1, 1'b1);
        checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_pulse got %0d exp 1", ov_cnt - ov0); end
        checks++; if (rx_if.rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept got %h exp 11", rx_if.rx_data); end
        checks++; if (rx_if.rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held got %b exp 1", rx_if.rx_valid); end
        @(negedge clk);
        rx_if.rx_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_drop got %b exp 0", rx_if.rx_valid); end
        $display("test_overrun 11 then 22 done");
    endtask

    task automatic test_reset_mid_frame();
        int pe0, fe0, ov0, v0;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data got %h exp 00", rx_if.rx_data); end
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_rx_valid got %b exp 0", rx_if.rx_valid); end
        checks++; if ({rx_if.parity_err, rx_if.frame_err, rx_if.overrun} !== 3'b000) begin errors++; $display("FAIL midrst_pulses got %b exp 000", {rx_if.parity_err, rx_if.frame_err, rx_if.overrun}); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt; v0 = val_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        checks++; if (rx_if.rx_data !== 8'hA5) begin errors++; $display("FAIL midrst_next_data got %h exp a5", rx_if.rx_data); end
        checks++; if (val_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_next_valid got %0d exp 1", val_cnt - v0); end
        checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin errors++; $display("FAIL midrst_no_errors got %0d exp 0", (pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0)); end
        $display("test_reset_mid_frame then a5 done");
    endtask

    task automatic test_enable_and_idle_noise();
        int pe0, fe0, ov0, v0;
        pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt; v0 = val_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        @(negedge clk);
        enable = 1'b0;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        repeat (2 * TMO) @(negedge clk);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin errors++; $display("FAIL enable_abort_silent got %0d exp 0", (pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0)); end
        checks++; if (rx_if.rx_data !== 8'hA5) begin errors++; $display("FAIL enable_data_kept got %h exp a5", rx_if.rx_data); end
        // a data=1 fall while idle must not be taken as a start bit
        ps2_bit(1'b1);
        repeat (5) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1);
        checks++; if (rx_if.rx_data !== 8'h3C) begin errors++; $display("FAIL idle_noise_data got %h exp 3c", rx_if.rx_data); end
        checks++; if (val_cnt - v0 !== 1) begin errors++; $display("FAIL idle_noise_valid got %0d exp 1", val_cnt - v0); end
        checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin errors++; $display("FAIL idle_noise_no_errors got %0d exp 0", (pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0)); end
        $display("test_enable_and_idle_noise then 3c done");
    endtask

    initial begin
        rx_if.rx_ready = 1'b1;
        test_reset();
        test_good_frame();
        test_parity_err();
        test_stop_err();
        test_timeout();
        test_overrun();
        test_reset_mid_frame();
        test_enable_and_idle_noise();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/ps2_rx_controller.md
# ps2_rx_controller

Receive-side controller for a PS/2 keyboard/mouse port. It synchronizes the external ps2_clk/ps2_data lines into the system clock domain and detects ps2_clk falling edges. It sequences an 11-bit frame (start, 8 data LSB-first, odd parity, stop) through a state machine and delivers each byte over a valid/ready handshake. It sits between the board PS/2 pins and the keyboard/mouse decode logic.

## Interface
- TIMEOUT_CYCLES, default 6000: maximum clk cycles allowed between consecutive ps2_clk falling edges inside a frame (120 us at 50 MHz).
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data pin, asynchronous to clk.
- enable  in  1  receiver enable; low forces IDLE.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- rx_data  out  8  received byte; valid while rx_valid is high.
- rx_valid  out  1  byte available; held until accepted.
- parity_err  out  1  one-cycle pulse: frame dropped, parity not odd.
- frame_err  out  1  one-cycle pulse: frame dropped, stop bit 0 or timeout.
- overrun  out  1  one-cycle pulse: good frame dropped because the output slot was still full.

## Operation
- Synchronizer: two flops each on ps2_clk and ps2_data, plus one history flop on the synced clock. Data and clock share the same stage depth.
- fall = history & ~synced_clk. bit = synced data in the same cycle.
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - fall with bit=0 (start bit) -> DATA; bit_cnt <= 0.
  - fall with bit=1 -> ignored; stay in IDLE.
- DATA: on each fall, shreg <= {bit, shreg[7:1]}, bit_cnt++. On the fall where bit_cnt==7 -> PARITY.
- PARITY: on fall, capture bit -> STOP.
- STOP: on fall -> IDLE, and resolve with this priority:
  - bit=0 -> frame_err pulse.
  - else if XOR(shreg, parity) != 1 -> parity_err pulse.
  - else deliver the byte.
- Deliver:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: rx_data <= shreg, rx_valid <= 1.
  - Otherwise: overrun pulse; rx_data keeps the old byte.
- Handshake: rx_valid drops at the clk edge where rx_valid & rx_ready, unless a deliver happens at that same edge.
- Timeout counter:
  - Cleared on every fall and while in IDLE; increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 outside IDLE -> frame_err pulse, go to IDLE, partial byte discarded.
  - It is 13 bits wide, with a static check that TIMEOUT_CYCLES < 8192.
- enable=0:
  - State -> IDLE next edge and any partial frame is aborted silently (no error pulse).
  - rx_valid/rx_data and the handshake are unaffected.
- Only one error/overrun pulse is possible per frame.

## Timing
- Reset values:
  - rx_data=0x00; rx_valid, parity_err, frame_err, overrun = 0.
  - State IDLE, counters 0.
  - Synchronizer and history flops reset to 1 (idle bus), so no false edge follows reset.
- Latency: if ps2_clk low is first sampled at clk edge k, fall is high between edges k+1 and k+2. The FSM acts at edge k+2. Outputs for the stop bit (rx_valid, error pulses) are visible after edge k+2.
- Reset asserted mid-frame: immediate return to reset values; the next frame must start with a fresh start bit.
- All outputs are registered.

## Structure
- Package ps2_rx_pkg holds:
  - state enum type (IDLE, DATA, PARITY, STOP);
  - PS2_DATA_W=8;
  - PS2_FRAME_BITS=11;
  - synchronizer reset constant 1'b1.
- Sub-module ps2_edge_detect: two-stage synchronizer for clk/data, history flop, fall output, aligned bit output.
- Top level: FSM, shift register, bit counter, timeout counter, output slot.

## Test plan
- Frame 0x5A, parity 1, stop 1, rx_ready=1 -> rx_valid high exactly one cycle, rx_data=0x5A, no error pulses, fires 2 clk edges after the stop-bit fall is sampled.
- Frame 0x5A with parity 0 -> parity_err pulse of 1 cycle; rx_valid stays 0; the next good frame 0x12 is received normally.
- Frame 0xFF with stop bit 0 -> frame_err pulse; rx_valid stays 0.
- Start plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse; state IDLE; a following frame 0x33 is received.
- rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, overrun pulse on the second frame. Raising rx_ready then drops rx_valid next edge.
- Reset asserted after 3 data bits, then released, then frame 0xA5 -> all outputs 0 during reset, then rx_data=0xA5, no errors. Also: enable=0 mid-frame -> no pulses; a data=1 fall in IDLE is ignored.
